// File: rtl/cska_pkg.sv
// Shared types and constants for the carry-skip add sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cska_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cska4_slice.sv
// 4-bit carry-skip adder slice: ripple of full-add cells plus an all-propagate bypass of the carry.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module cska4_slice
    import cska_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               skip
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W:0]   c;

    // Half-add terms per bit, then the full-add ripple chain; the skip mux picks cin when every bit propagates.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        s    = p ^ c[SLICE_W-1:0];
        skip = &p;
        cout = skip ? cin : c[SLICE_W];
    end

endmodule

// File: rtl/cska_seq_ctrl.sv
// Wide adder built by stepping one 4-bit carry-skip slice from LSB to MSB, carry kept in a flop.
// Latency: out_valid rises NSLICE clocks after the accept edge; one add per NSLICE+2 cycles at best.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, so no accept while busy or holding.
module cska_seq_ctrl
    import cska_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               a,
    input  logic [WIDTH-1:0]               b,
    input  logic                           cin,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               sum,
    output logic                           cout,
    output logic [$clog2(WIDTH/4+1)-1:0]   skip_cnt,
    output logic                           busy
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CW     = $clog2(NSLICE + 1);
    localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

    state_t            state;
    state_t            state_nxt;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic              carry;
    logic [IW-1:0]     idx;

    logic [SLICE_W-1:0] a_nib;
    logic [SLICE_W-1:0] b_nib;
    logic [SLICE_W-1:0] s_nib;
    logic               slice_co;
    logic               slice_skip;

    assign a_nib = a_reg[idx*SLICE_W +: SLICE_W];
    assign b_nib = b_reg[idx*SLICE_W +: SLICE_W];

    cska4_slice u_slice (
        .a    (a_nib),
        .b    (b_nib),
        .cin  (carry),
        .s    (s_nib),
        .cout (slice_co),
        .skip (slice_skip)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs; the last slice cycle moves straight to DONE.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture on accept, then one nibble of sum and the carry per RUN cycle; DONE holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            skip_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum      <= '0;
                        skip_cnt <= '0;
                    end
                end
                RUN: begin
                    sum[idx*SLICE_W +: SLICE_W] <= s_nib;
                    carry <= slice_co;
                    if (slice_skip) begin
                        skip_cnt <= skip_cnt + CW'(1);
                    end
                    if (idx == LAST) begin
                        cout <= slice_co;
                        idx  <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cska_seq_ctrl.sv
module tb_cska_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic [2:0]  skip_cnt;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    cska_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .skip_cnt  (skip_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        int          sk;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic plus a count of nibbles whose xor is all ones.
    function automatic logic [16:0] ref_add(logic [15:0] x, logic [15:0] y, logic c);
        return {1'b0, x} + {1'b0, y} + {16'd0, c};
    endfunction

    function automatic int ref_skip(logic [15:0] x, logic [15:0] y);
        int n;
        logic [15:0] p;
        n = 0;
        p = x ^ y;
        for (int k = 0; k < 4; k++) begin
            if (p[4*k +: 4] == 4'hF) n++;
        end
        return n;
    endfunction

    // Present operands, returns just after the accept edge with inputs scrambled.
    task automatic accept_op(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        int n;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
    endtask

    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic full_op(input string nm, input logic [15:0] va, input logic [15:0] vb,
                           input logic vc, input logic [15:0] es, input logic eco, input int esk);
        int lat;
        accept_op(va, vb, vc);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        wait_result(lat);
        chk({nm, "_latency"}, 32'(lat), 32'd4);
        chk({nm, "_sum"}, 32'(sum), 32'(es));
        chk({nm, "_cout"}, 32'(cout), 32'(eco));
        chk({nm, "_skip"}, 32'(skip_cnt), 32'(esk));
        release_op();
        chk({nm, "_ovld_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        logic [16:0] r;
        logic [15:0] ra, rb;
        logic rc;

        vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 0};
        vt[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 4};
        vt[2] = '{16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 4};
        vt[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 0};
        vt[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 0};
        vt[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1, 4};
        vt[6] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 2};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_skip", 32'(skip_cnt), 32'd0);
        rst = 1'b0;

        // Directed table.
        for (int i = 0; i < 7; i++) begin
            full_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].cin, vt[i].s, vt[i].co, vt[i].sk);
        end

        // Randomized against the reference; every third op biased towards propagate-heavy nibbles.
        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            if (i % 3 == 0) rb = ~ra ^ (16'h000F << (4 * $urandom_range(0, 3)));
            r = ref_add(ra, rb, rc);
            full_op($sformatf("rnd%0d", i), ra, rb, rc, r[15:0], r[16], ref_skip(ra, rb));
        end

        // Backpressure: result held while a new request waits.
        accept_op(16'h1234, 16'h0FFF, 1'b0);
        wait_result(lat);
        chk("bp_latency", 32'(lat), 32'd4);
        @(negedge clk);
        in_valid = 1'b1; a = 16'h1111; b = 16'h0000; cin = 1'b0; out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum_hold", 32'(sum), 32'h2233);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_ovld", 32'(out_valid), 32'd0);
        chk("bp_idle_in_ready", 32'(in_ready), 32'd1);
        chk("bp_idle_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0; a = 16'hBEEF; b = 16'hCAFE;
        chk("bp_accept_busy", 32'(busy), 32'd1);
        wait_result(lat);
        chk("bp2_latency", 32'(lat), 32'd4);
        chk("bp2_sum", 32'(sum), 32'h1111);
        chk("bp2_cout", 32'(cout), 32'd0);
        release_op();

        // Reset in the middle of RUN.
        accept_op(16'h1111, 16'h1111, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_partial_sum", 32'(sum), 32'h0022);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_sum", 32'(sum), 32'd0);
        chk("mr_skip", 32'(skip_cnt), 32'd0);
        chk("mr_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        full_op("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 0);

        // Idle robustness.
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_sum", 32'(sum), 32'h0002);
        end
        out_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
